stream_demux_1to4: RTL and testbench
====================================

STREAM_DEMUX_1TO4 -- requirements
Module: stream_demux_1to4

Interface
REQ-001 Parameter: DATA_W, default 8, width of each data word.
REQ-002 Parameter: CNT_W, default 8, width of each per-output delivery counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset_n  input  1  reset, synchronous, active-low.
REQ-005 in_valid  input  1  upstream word present.
REQ-006 in_data  input  DATA_W  upstream word.
REQ-007 in_sel  input  2  destination output index, used when rr_mode=0.
REQ-008 rr_mode  input  1  1 = round-robin destination from internal pointer; 0 = destination is in_sel.
REQ-009 in_ready  output  1  word accepted this cycle when in_valid & in_ready.
REQ-010 out_valid  output  4  per-output word present.
REQ-011 out_data  output  4 x DATA_W  per-output held word.
REQ-012 out_ready  input  4  per-output downstream acceptance.
REQ-013 rr_ptr  output  2  current round-robin pointer.
REQ-014 deliver_cnt  output  4 x CNT_W  per-output count of completed transfers (out_valid[i] & out_ready[i]).

Function
REQ-015 Destination dest SHALL be rr_ptr when rr_mode=1, else in_sel, evaluated combinationally each cycle.
REQ-016 Each output i SHALL own a one-entry slot; out_valid[i] = slot full; out_data[i] = slot contents.
REQ-017 in_ready SHALL equal ~out_valid[dest] | out_ready[dest] (combinational; no dependence on in_valid).
REQ-018 On acceptance, the word SHALL be written to slot dest and out_valid[dest] SHALL be 1 the next cycle (latency 1 cycle).
REQ-019 A full slot SHALL hold out_data[i] stable and out_valid[i]=1 until out_ready[i]=1.
REQ-020 Drain and refill of the same slot in one cycle SHALL leave the slot full with the new word; no bubble.
REQ-021 Drain without refill SHALL clear out_valid[i] the next cycle; out_data[i] SHALL retain its last value.
REQ-022 Slots not equal to dest SHALL drain independently and concurrently with any acceptance.
REQ-023 rr_ptr SHALL advance by 1 modulo 4 (3 -> 0) only on an accepted word with rr_mode=1; otherwise it SHALL hold.
REQ-024 Changing rr_mode SHALL not modify rr_ptr; round-robin resumes from the held value.
REQ-025 A blocked round-robin destination SHALL stall input (in_ready=0); the pointer SHALL NOT skip to a free slot.
REQ-026 deliver_cnt[i] SHALL increment by 1 on each out_valid[i] & out_ready[i] cycle and wrap from 2^CNT_W-1 to 0.
REQ-027 out_ready[i] with out_valid[i]=0 SHALL have no effect on slot or counter.
REQ-028 in_data/in_sel SHALL be ignored when in_valid=0; no slot, pointer or counter change.

Reset
REQ-029 With reset_n=0 at a rising edge: all out_valid=0, all out_data=0, rr_ptr=0, all deliver_cnt=0.
REQ-030 Reset mid-operation SHALL discard every held word; no transfer SHALL complete in the reset cycle.
REQ-031 in_ready SHALL follow REQ-017 during reset (all slots then empty after the edge).

Structure
REQ-032 Shared package demux_pkg SHALL hold NUM_OUTS=4 and typedef sel_t (2-bit destination index).
REQ-033 One sub-module demux_slot (one-entry buffer: load, drain, valid, data, delivery counter) SHALL be instantiated 4 times; top holds dest select, in_ready and rr_ptr.

Verification
REQ-034 Reset, rr_mode=0, in_sel=2, in_data=0xA5, in_valid 1 cycle, out_ready=0 -> next cycle out_valid=4'b0100, out_data[2]=0xA5, held indefinitely.
REQ-035 Slot 2 full, out_ready[2]=0, second word in_sel=2 -> in_ready=0; raise out_ready[2] with word 0x3C -> in_ready=1, next cycle out_data[2]=0x3C, out_valid[2]=1, deliver_cnt[2]=1.
REQ-036 rr_mode=1, all out_ready=1, five words 0x10..0x14 back-to-back -> delivered to outputs 0,1,2,3,0; rr_ptr ends at 1; in_ready constantly 1.
REQ-037 rr_mode=1, rr_ptr=1, out_valid[1]=1, out_ready[1]=0 -> in_ready=0, rr_ptr stays 1 though slots 0,2,3 empty.
REQ-038 out_ready[0]=1 continuously, 256 words to output 0 -> deliver_cnt[0] wraps to 0 (CNT_W=8).
REQ-039 Slots 0 and 3 full, reset_n=0 one cycle -> out_valid=0, out_data=0, rr_ptr=0, deliver_cnt=0, no counter increment.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared definitions for the 1-to-4 stream demultiplexer.
package demux_pkg;

    localparam int NUM_OUTS = 4;

    // Destination index for one of the NUM_OUTS outputs.
    typedef logic [1:0] sel_t;

    // Round-robin successor; the 2-bit width gives the 3 -> 0 wrap.
    function automatic sel_t next_sel(input sel_t cur);
        return sel_t'(cur + 2'd1);
    endfunction

endpackage

// File: rtl/stream_demux_1to4_if.sv
// Bus bundle between the upstream/downstream environment and the demux.
interface stream_demux_1to4_if #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
);
    import demux_pkg::*;

    logic                             in_valid;
    logic [DATA_W-1:0]                in_data;
    sel_t                             in_sel;
    logic                             rr_mode;
    logic                             in_ready;
    logic [NUM_OUTS-1:0]              out_valid;
    logic [NUM_OUTS-1:0][DATA_W-1:0]  out_data;
    logic [NUM_OUTS-1:0]              out_ready;
    sel_t                             rr_ptr;
    logic [NUM_OUTS-1:0][CNT_W-1:0]   deliver_cnt;

    // Environment side: drives the upstream word and downstream acceptance.
    modport master (
        output in_valid, in_data, in_sel, rr_mode, out_ready,
        input  in_ready, out_valid, out_data, rr_ptr, deliver_cnt
    );

    // Demux side.
    modport slave (
        input  in_valid, in_data, in_sel, rr_mode, out_ready,
        output in_ready, out_valid, out_data, rr_ptr, deliver_cnt
    );

endinterface

// File: rtl/demux_slot.sv
// One-entry output buffer with a wrapping delivery counter.
// A drain and a load in the same cycle keep the slot full with the new word.
module demux_slot #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load_i,
    input  logic [DATA_W-1:0] din_i,
    input  logic              ready_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic [CNT_W-1:0]  cnt_o
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q,  data_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;

    // Next-state: drain first, then a load overrides the valid flag and data.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        if (valid_q && ready_i) begin
            valid_d = 1'b0;
            cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d   = cnt_q;
        end
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = din_i;
        end else begin
            data_d  = data_q;
        end
    end

    // Slot state register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            data_q  <= {DATA_W{1'b0}};
            cnt_q   <= {CNT_W{1'b0}};
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign cnt_o   = cnt_q;

endmodule

// File: rtl/stream_demux_1to4.sv
// 1-to-4 stream demultiplexer: steers each accepted word to one of four
// one-entry output slots, chosen by in_sel or by a round-robin pointer.
// A blocked round-robin destination stalls input rather than skipping ahead.
module stream_demux_1to4
    import demux_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    stream_demux_1to4_if.slave   bus
);

    sel_t                rr_ptr_q, rr_ptr_d;
    sel_t                dest_s;
    logic                accept_s;
    logic [NUM_OUTS-1:0] load_s;

    // Destination select, readiness and per-slot load strobes.
    always_comb begin
        dest_s      = bus.rr_mode ? rr_ptr_q : bus.in_sel;
        bus.in_ready = ~bus.out_valid[dest_s] | bus.out_ready[dest_s];
        accept_s    = bus.in_valid & bus.in_ready;
        load_s      = {NUM_OUTS{1'b0}};
        if (accept_s) begin
            load_s[dest_s] = 1'b1;
        end else begin
            load_s = {NUM_OUTS{1'b0}};
        end
        if (accept_s && bus.rr_mode) begin
            rr_ptr_d = next_sel(rr_ptr_q);
        end else begin
            rr_ptr_d = rr_ptr_q;
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rr_ptr_q <= 2'd0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign bus.rr_ptr = rr_ptr_q;

    for (genvar g = 0; g < NUM_OUTS; g++) begin : g_slot
        demux_slot #(
            .DATA_W (DATA_W),
            .CNT_W  (CNT_W)
        ) u_slot (
            .clk     (clk),
            .reset_n (reset_n),
            .load_i  (load_s[g]),
            .din_i   (bus.in_data),
            .ready_i (bus.out_ready[g]),
            .valid_o (bus.out_valid[g]),
            .data_o  (bus.out_data[g]),
            .cnt_o   (bus.deliver_cnt[g])
        );
    end

endmodule

// File: tb/tb_stream_demux_1to4.sv
// Directed testbench for stream_demux_1to4.
module tb_stream_demux_1to4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    stream_demux_1to4_if #(.DATA_W(8), .CNT_W(8)) bus ();

    stream_demux_1to4 #(.DATA_W(8), .CNT_W(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Advance one rising edge; sample point is 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.in_sel    = 2'd0;
        bus.rr_mode   = 1'b0;
        bus.out_ready = 4'b0000;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hEE;
        reset_n = 1'b0;
        step();
        step();
        checks++;
        if (bus.out_valid !== 4'b0000) begin failures++; $display("FAIL reset_valid got=%b exp=0000", bus.out_valid); end
        checks++;
        if (bus.out_data !== 32'h0) begin failures++; $display("FAIL reset_data got=%h exp=00000000", bus.out_data); end
        checks++;
        if (bus.rr_ptr !== 2'd0) begin failures++; $display("FAIL reset_ptr got=%0d exp=0", bus.rr_ptr); end
        checks++;
        if (bus.deliver_cnt !== 32'h0) begin failures++; $display("FAIL reset_cnt got=%h exp=00000000", bus.deliver_cnt); end
        checks++;
        if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
        idle_inputs();
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_single();
        bus.rr_mode  = 1'b0;
        bus.in_sel   = 2'd2;
        bus.in_data  = 8'hA5;
        bus.in_valid = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL single_ready got=%b exp=1", bus.in_ready); end
        step();
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h99;
        bus.in_sel   = 2'd1;
        checks++;
        if (bus.out_valid !== 4'b0100) begin failures++; $display("FAIL single_valid got=%b exp=0100", bus.out_valid); end
        checks++;
        if (bus.out_data[2] !== 8'hA5) begin failures++; $display("FAIL single_data got=%h exp=a5", bus.out_data[2]); end
        repeat (5) step();
        checks++;
        if (bus.out_valid !== 4'b0100 || bus.out_data[2] !== 8'hA5)
            begin failures++; $display("FAIL single_hold got=%b/%h exp=0100/a5", bus.out_valid, bus.out_data[2]); end
        checks++;
        if (bus.deliver_cnt !== 32'h0 || bus.rr_ptr !== 2'd0)
            begin failures++; $display("FAIL ignore_idle got=%h/%0d exp=0/0", bus.deliver_cnt, bus.rr_ptr); end
    endtask

    task automatic test_backpressure();
        bus.in_sel   = 2'd2;
        bus.in_data  = 8'h77;
        bus.in_valid = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL bp_stall got=%b exp=0", bus.in_ready); end
        step();
        checks++;
        if (bus.out_data[2] !== 8'hA5) begin failures++; $display("FAIL bp_no_overwrite got=%h exp=a5", bus.out_data[2]); end
        bus.in_data   = 8'h3C;
        bus.out_ready = 4'b0100;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL bp_release got=%b exp=1", bus.in_ready); end
        step();
        bus.in_valid  = 1'b0;
        bus.out_ready = 4'b0000;
        checks++;
        if (bus.out_valid !== 4'b0100 || bus.out_data[2] !== 8'h3C)
            begin failures++; $display("FAIL bp_refill got=%b/%h exp=0100/3c", bus.out_valid, bus.out_data[2]); end
        checks++;
        if (bus.deliver_cnt[2] !== 8'd1) begin failures++; $display("FAIL bp_cnt got=%0d exp=1", bus.deliver_cnt[2]); end
        // Drain without refill.
        bus.out_ready = 4'b0100;
        step();
        bus.out_ready = 4'b0000;
        checks++;
        if (bus.out_valid !== 4'b0000 || bus.out_data[2] !== 8'h3C || bus.deliver_cnt[2] !== 8'd2)
            begin failures++; $display("FAIL drain got=%b/%h/%0d exp=0000/3c/2", bus.out_valid, bus.out_data[2], bus.deliver_cnt[2]); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_word;
        logic [1:0] exp_dest;
        do_reset();
        bus.rr_mode   = 1'b1;
        bus.out_ready = 4'b1111;
        bus.in_sel    = 2'd3;
        for (int i = 0; i < 5; i++) begin
            exp_word = 8'h10 + 8'(i);
            exp_dest = 2'(i);
            bus.in_data  = exp_word;
            bus.in_valid = 1'b1;
            #1;
            checks++;
            if (bus.in_ready !== 1'b1 || bus.rr_ptr !== exp_dest)
                begin failures++; $display("FAIL rr_ready_ptr i=%0d got=%b/%0d exp=1/%0d", i, bus.in_ready, bus.rr_ptr, exp_dest); end
            step();
            checks++;
            if (bus.out_valid[exp_dest] !== 1'b1 || bus.out_data[exp_dest] !== exp_word)
                begin failures++; $display("FAIL rr_dest i=%0d got=%b/%h exp=1/%h", i, bus.out_valid[exp_dest], bus.out_data[exp_dest], exp_word); end
        end
        bus.in_valid = 1'b0;
        step();
        checks++;
        if (bus.rr_ptr !== 2'd1) begin failures++; $display("FAIL rr_end_ptr got=%0d exp=1", bus.rr_ptr); end
        checks++;
        if (bus.deliver_cnt !== {8'd1, 8'd1, 8'd1, 8'd2})
            begin failures++; $display("FAIL rr_cnts got=%h exp=01010102", bus.deliver_cnt); end
        checks++;
        if (bus.out_valid !== 4'b0000 || bus.out_data !== {8'h13, 8'h12, 8'h11, 8'h14})
            begin failures++; $display("FAIL rr_final got=%b/%h exp=0000/13121114", bus.out_valid, bus.out_data); end
    endtask

    task automatic test_rr_block();
        // rr_ptr is 1. Fill slot 1 via in_sel with rr_mode=0: pointer must hold.
        bus.out_ready = 4'b0000;
        bus.rr_mode   = 1'b0;
        bus.in_sel    = 2'd1;
        bus.in_data   = 8'h55;
        bus.in_valid  = 1'b1;
        step();
        checks++;
        if (bus.rr_ptr !== 2'd1 || bus.out_valid !== 4'b0010)
            begin failures++; $display("FAIL sel_mode_ptr got=%0d/%b exp=1/0010", bus.rr_ptr, bus.out_valid); end
        bus.rr_mode = 1'b1;
        bus.in_sel  = 2'd0;
        bus.in_data = 8'h66;
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL rr_block_ready got=%b exp=0", bus.in_ready); end
        step();
        checks++;
        if (bus.rr_ptr !== 2'd1 || bus.out_valid !== 4'b0010 || bus.out_data[1] !== 8'h55)
            begin failures++; $display("FAIL rr_no_skip got=%0d/%b/%h exp=1/0010/55", bus.rr_ptr, bus.out_valid, bus.out_data[1]); end
        bus.out_ready = 4'b0010;
        step();
        bus.in_valid  = 1'b0;
        bus.out_ready = 4'b0000;
        checks++;
        if (bus.rr_ptr !== 2'd2 || bus.out_data[1] !== 8'h66 || bus.out_valid !== 4'b0010)
            begin failures++; $display("FAIL rr_resume got=%0d/%h/%b exp=2/66/0010", bus.rr_ptr, bus.out_data[1], bus.out_valid); end
    endtask

    task automatic test_cnt_wrap();
        logic ready_ok;
        ready_ok = 1'b1;
        do_reset();
        bus.rr_mode   = 1'b0;
        bus.in_sel    = 2'd0;
        bus.out_ready = 4'b0001;
        for (int i = 0; i < 256; i++) begin
            bus.in_data  = 8'(i);
            bus.in_valid = 1'b1;
            #1;
            if (bus.in_ready !== 1'b1) ready_ok = 1'b0;
            step();
        end
        checks++;
        if (ready_ok !== 1'b1) begin failures++; $display("FAIL wrap_ready got=%b exp=1", ready_ok); end
        checks++;
        if (bus.deliver_cnt[0] !== 8'hFF || bus.out_data[0] !== 8'hFF)
            begin failures++; $display("FAIL wrap_max got=%h/%h exp=ff/ff", bus.deliver_cnt[0], bus.out_data[0]); end
        bus.in_valid = 1'b0;
        step();
        checks++;
        if (bus.deliver_cnt[0] !== 8'h00 || bus.out_valid !== 4'b0000)
            begin failures++; $display("FAIL wrap_zero got=%h/%b exp=00/0000", bus.deliver_cnt[0], bus.out_valid); end
        // Ready with empty slots must not count.
        bus.out_ready = 4'b1111;
        bus.in_data   = 8'h42;
        step();
        checks++;
        if (bus.deliver_cnt !== 32'h0 || bus.out_valid !== 4'b0000)
            begin failures++; $display("FAIL empty_ready got=%h/%b exp=0/0000", bus.deliver_cnt, bus.out_valid); end
        bus.out_ready = 4'b0000;
    endtask

    task automatic test_reset_mid();
        bus.rr_mode  = 1'b1;
        bus.in_data  = 8'hAA;
        bus.in_valid = 1'b1;
        step();
        bus.rr_mode = 1'b0;
        bus.in_sel  = 2'd3;
        bus.in_data = 8'hBB;
        step();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 4'b1001 || bus.rr_ptr !== 2'd1)
            begin failures++; $display("FAIL mid_setup got=%b/%0d exp=1001/1", bus.out_valid, bus.rr_ptr); end
        bus.out_ready = 4'b1111;
        bus.in_valid  = 1'b1;
        bus.in_sel    = 2'd1;
        bus.in_data   = 8'hCC;
        reset_n = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL mid_in_ready got=%b exp=1", bus.in_ready); end
        step();
        checks++;
        if (bus.out_valid !== 4'b0000 || bus.out_data !== 32'h0 || bus.rr_ptr !== 2'd0 || bus.deliver_cnt !== 32'h0)
            begin failures++; $display("FAIL mid_reset got=%b/%h/%0d/%h exp=0000/0/0/0", bus.out_valid, bus.out_data, bus.rr_ptr, bus.deliver_cnt); end
        reset_n = 1'b1;
        idle_inputs();
        step();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_rr_block();
        test_cnt_wrap();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
